fir_sample_filter: RTL and testbench

- Parametrised FIR post-processor for ADC samples.
- Generalises the fixed-coefficient differentiator to N taps, selectable coefficient sets and configurable sample width.
- Computes one output per accepted sample using a serial multiply-accumulate, with output saturation and an overrun flag.
- Sits between ADC_Driver sample output and the DAC_Driver channel-B input; the sample strobe is derived from the DAC channel toggle.

---
 rtl/fir_filter_pkg.sv | 49 ++++
 rtl/fir_coef_rom.sv | 24 ++
 rtl/fir_sample_filter.sv | 162 ++++++++++++++++
 tb/tb_fir_sample_filter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_filter_pkg.sv
// Shared definitions for the FIR sample filter: mode encodings, the
// per-mode coefficient and shift tables, and the MAC sequencer states.
package fir_filter_pkg;

    localparam int NUM_MODES  = 4;
    localparam int DEF_TAPS   = 3;
    localparam int TBL_COEF_W = 4;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_DELAY = 2'd1,
        MODE_DIFF1 = 2'd2,
        MODE_DIFF2 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_e;

    typedef logic signed [TBL_COEF_W-1:0] coef_t;

    // Coefficients c0..c2 per mode; c0 multiplies the newest sample.
    localparam coef_t COEF_TABLE [NUM_MODES][DEF_TAPS] = '{
        '{ 4'sd1,  4'sd0,  4'sd0},   // PASS
        '{ 4'sd0,  4'sd1,  4'sd0},   // DELAY
        '{ 4'sd1, -4'sd1,  4'sd0},   // DIFF1
        '{ 4'sd3, -4'sd4,  4'sd1}    // DIFF2
    };

    // Right shift applied to the accumulator before output per mode.
    localparam logic [1:0] SHIFT_TABLE [NUM_MODES] = '{2'd0, 2'd0, 2'd0, 2'd1};

    // Taps past the defined set contribute nothing.
    function automatic coef_t coef_lookup(input mode_e m, input int unsigned k);
        coef_t c;
        c = '0;
        if (k < DEF_TAPS) begin
            c = COEF_TABLE[m][k[1:0]];
        end
        return c;
    endfunction

    function automatic logic [1:0] mode_shift(input mode_e m);
        return SHIFT_TABLE[m];
    endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// Combinational coefficient lookup: (mode, tap index) -> signed coefficient.
// Tap indices beyond the three defined taps return zero.
module fir_coef_rom
    import fir_filter_pkg::*;
#(
    parameter int COEF_W = 4,
    parameter int K_W    = 2
) (
    input  logic [1:0]               i_mode,
    input  logic [K_W-1:0]           i_k,
    output logic signed [COEF_W-1:0] o_coef
);

    coef_t w_tbl;

    // Table read, sign-extended (or narrowed) to the configured width.
    always_comb begin
        w_tbl = '0;
        w_tbl = coef_lookup(mode_e'(i_mode), 32'(i_k));
    end

    assign o_coef = COEF_W'(w_tbl);

endmodule

// File: rtl/fir_sample_filter.sv
// FIR post-processor for ADC samples. One accepted sample starts a serial
// multiply-accumulate over the delay line (one tap per cycle), then the
// result is shifted, range-limited and registered with a one-cycle pulse.
// Build option: define FIR_SATURATE_EN to clamp out-of-range results;
// otherwise the low WIDTH bits are kept (two's-complement wrap).
module fir_sample_filter
    import fir_filter_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int TAPS   = 3,
    parameter int COEF_W = 4,
    parameter int ACC_W  = WIDTH + COEF_W + $clog2(TAPS)
) (
    input  logic                    CLK_50M,
    input  logic                    RST,
    input  logic                    sample_valid,
    input  logic signed [WIDTH-1:0] sample_in,
    input  logic [1:0]              mode,
    input  logic                    clear_ovr,
    output logic signed [WIDTH-1:0] sample_out,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int              K_W    = $clog2(TAPS);
    localparam logic [K_W-1:0]  K_LAST = K_W'(TAPS - 1);

    localparam logic signed [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_e                   r_state;
    mode_e                    r_mode;
    logic [K_W-1:0]           r_k;
    logic signed [ACC_W-1:0]  r_acc;
    logic [TAPS-1:0][WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0]  r_sample_out;
    logic                     r_out_valid;
    logic                     r_busy;
    logic                     r_overrun;

    logic                     w_accept;
    logic                     w_drop;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [ACC_W-1:0]  w_coef_ext;
    logic signed [ACC_W-1:0]  w_x_ext;
    logic signed [ACC_W-1:0]  w_term;
    logic [1:0]               w_shift;
    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [WIDTH-1:0]  w_result;

    // Samples are only taken while idle; the OUT cycle counts as busy.
    assign w_accept = sample_valid && (r_state == IDLE);
    assign w_drop   = sample_valid && (r_state != IDLE);

    fir_coef_rom #(
        .COEF_W (COEF_W),
        .K_W    (K_W)
    ) u_coef_rom (
        .i_mode (r_mode),
        .i_k    (r_k),
        .o_coef (w_coef)
    );

    // One product term per cycle, both operands widened before multiplying.
    assign w_coef_ext = ACC_W'(w_coef);
    assign w_x_ext    = ACC_W'($signed(r_x[r_k]));
    assign w_term     = w_coef_ext * w_x_ext;

    // Arithmetic shift floors toward minus infinity.
    assign w_shift   = mode_shift(r_mode);
    assign w_shifted = r_acc >>> w_shift;

`ifdef FIR_SATURATE_EN
    // Clamp the shifted result into the signed output range.
    always_comb begin
        w_result = w_shifted[WIDTH-1:0];
        if (w_shifted > ACC_W'(OUT_MAX)) begin
            w_result = OUT_MAX;
        end else if (w_shifted < ACC_W'(OUT_MIN)) begin
            w_result = OUT_MIN;
        end
    end
`else
    // Keep the low bits of the shifted result (wraps on overflow).
    always_comb begin
        w_result = w_shifted[WIDTH-1:0];
    end
`endif

    // Delay line: newest sample enters at x[0] on accept only.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            r_x <= '0;
        end else if (w_accept) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                r_x[i] <= r_x[i-1];
            end
            r_x[0] <= sample_in;
        end
    end

    // MAC sequencer IDLE -> MAC (TAPS cycles) -> OUT, with registered outputs.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            r_state      <= IDLE;
            r_mode       <= MODE_PASS;
            r_k          <= '0;
            r_acc        <= '0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_sample_out <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sample_valid) begin
                        r_mode  <= mode_e'(mode);
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_term;
                    if (r_k == K_LAST) begin
                        r_state <= OUT;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                OUT: begin
                    r_sample_out <= w_result;
                    r_out_valid  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clear_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    assign sample_out = r_sample_out;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_fir_sample_filter.sv
// Directed bench for fir_sample_filter (default parameters: WIDTH=14, TAPS=3).
module tb_fir_sample_filter;

    logic               clk = 1'b0;
    logic               RST = 1'b1;
    logic               sample_valid = 1'b0;
    logic signed [13:0] sample_in = '0;
    logic [1:0]         mode = 2'd0;
    logic               clear_ovr = 1'b0;
    logic signed [13:0] sample_out;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    int checks = 0;
    int errors = 0;

    fir_sample_filter dut (
        .CLK_50M      (clk),
        .RST          (RST),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .mode         (mode),
        .clear_ovr    (clear_ovr),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #10 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        sample_valid = 1'b0;
        clear_ovr = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Strobe one sample, wait (bounded) for out_valid; lat counts cycles from
    // the strobe cycle (0) to the cycle in which out_valid is seen.
    task automatic send(input int val, input logic [1:0] m,
                        output logic signed [13:0] res, output int lat);
        sample_valid = 1'b1;
        sample_in = 14'(val);
        mode = m;
        tick();
        sample_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        res = sample_out;
        $display("txn: mode=%0d in=%0d out=%0d latency=%0d", m, val, res, lat);
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sample_out !== 14'sd0) begin errors++; $display("FAIL reset_sample_out: got %0d expected 0", sample_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_diff2_step();
        int xs[5] = '{0, 0, 1000, 1000, 1000};
        int ex[5] = '{0, 0, 1500, -500, 0};
        logic signed [13:0] r;
        int lat;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(xs[i], 2'd3, r, lat);
            checks++; if (r !== 14'(ex[i])) begin errors++; $display("FAIL diff2_step[%0d]: got %0d expected %0d", i, r, ex[i]); end
            checks++; if (lat != 5) begin errors++; $display("FAIL diff2_latency[%0d]: got %0d expected 5", i, lat); end
        end
    endtask

    task automatic test_diff2_floor();
        int xs[3] = '{1, 0, 0};
        int ex[3] = '{1, -2, 0};
        logic signed [13:0] r;
        int lat;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(xs[i], 2'd3, r, lat);
            checks++; if (r !== 14'(ex[i])) begin errors++; $display("FAIL diff2_floor[%0d]: got %0d expected %0d", i, r, ex[i]); end
        end
    endtask

    task automatic test_ramp();
        int xs[4] = '{0, 100, 200, 300};
        int ex_diff[4] = '{0, 100, 100, 100};
        int ex_delay[4] = '{0, 0, 100, 200};
        logic signed [13:0] r;
        int lat;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(xs[i], 2'd2, r, lat);
            checks++; if (r !== 14'(ex_diff[i])) begin errors++; $display("FAIL ramp_diff1[%0d]: got %0d expected %0d", i, r, ex_diff[i]); end
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(xs[i], 2'd1, r, lat);
            checks++; if (r !== 14'(ex_delay[i])) begin errors++; $display("FAIL ramp_delay[%0d]: got %0d expected %0d", i, r, ex_delay[i]); end
        end
    endtask

    task automatic test_overflow();
        logic signed [13:0] r;
        int lat;
        int ex;
`ifdef FIR_SATURATE_EN
        ex = -8192;
`else
        ex = 1;
`endif
        do_reset();
        send(8191, 2'd2, r, lat);
        checks++; if (r !== 14'sd8191) begin errors++; $display("FAIL overflow_first: got %0d expected 8191", r); end
        send(-8192, 2'd2, r, lat);
        checks++; if (r !== 14'(ex)) begin errors++; $display("FAIL overflow_second: got %0d expected %0d", r, ex); end
    endtask

    task automatic test_overrun();
        logic signed [13:0] r;
        int lat;
        do_reset();
        // strobe at cycle 0, second strobe at cycle 2 lands mid-MAC
        sample_valid = 1'b1; sample_in = 14'sd500; mode = 2'd0;
        tick();
        sample_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL overrun_busy_high: got %b expected 1", busy); end
        tick();
        sample_valid = 1'b1; sample_in = 14'sd777;
        tick();
        sample_valid = 1'b0;
        lat = 3;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        $display("txn: overrun first sample out=%0d latency=%0d", sample_out, lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL overrun_latency: got %0d expected 5", lat); end
        checks++; if (sample_out !== 14'sd500) begin errors++; $display("FAIL overrun_kept_sample: got %0d expected 500", sample_out); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL out_valid_one_cycle: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overrun_busy_low: got %b expected 0", busy); end
        // dropped 777 must not be in the history: 600 - 500 = 100
        send(600, 2'd2, r, lat);
        checks++; if (r !== 14'sd100) begin errors++; $display("FAIL overrun_history: got %0d expected 100", r); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
        // clear coinciding with a new drop: set wins
        sample_valid = 1'b1; sample_in = 14'sd10; mode = 2'd0;
        tick();
        sample_in = 14'sd20; clear_ovr = 1'b1;
        tick();
        sample_valid = 1'b0; clear_ovr = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins: got %b expected 1", overrun); end
        lat = 2;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        $display("txn: set-wins sample out=%0d latency=%0d", sample_out, lat);
        checks++; if (sample_out !== 14'sd10) begin errors++; $display("FAIL set_wins_sample: got %0d expected 10", sample_out); end
        tick();
    endtask

    task automatic test_reset_mid_mac();
        logic signed [13:0] r;
        int lat;
        int pulses;
        sample_valid = 1'b1; sample_in = 14'sd1234; mode = 2'd2;
        tick();
        sample_valid = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        checks++; if (sample_out !== 14'sd0) begin errors++; $display("FAIL midmac_sample_out: got %0d expected 0", sample_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midmac_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midmac_overrun: got %b expected 0", overrun); end
        RST = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        $display("txn: reset mid-MAC, out_valid pulses after abort=%0d", pulses);
        checks++; if (pulses != 0) begin errors++; $display("FAIL midmac_no_out_valid: got %0d expected 0", pulses); end
        send(321, 2'd0, r, lat);
        checks++; if (r !== 14'sd321) begin errors++; $display("FAIL midmac_pass: got %0d expected 321", r); end
        checks++; if (lat != 5) begin errors++; $display("FAIL midmac_latency: got %0d expected 5", lat); end
        // x = 0, 321, 0 (1234 flushed): (0 - 1284 + 0) >>> 1 = -642
        send(0, 2'd3, r, lat);
        checks++; if (r !== -14'sd642) begin errors++; $display("FAIL midmac_history_cleared: got %0d expected -642", r); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_diff2_step();
        test_diff2_floor();
        test_ramp();
        test_overflow();
        test_overrun();
        test_reset_mid_mac();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
